screen_memory: RTL and testbench

SCREEN_MEMORY -- requirements
Module: screen_memory

---
 rtl/screen_memory.sv | 200 ++++++++++++++++++++
 tb/tb_screen_memory.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/screen_memory.sv
// 64x32 monochrome screen store: 256x8 single-port RAM shared between a
// display read port (priority) and a sprite-XOR / clear engine.
module screen_memory (
    input  logic       clk,
    input  logic       reset,
    input  logic       scr_read,
    input  logic [7:0] scr_read_idx,
    output logic [7:0] scr_read_byte,
    output logic       scr_read_ack,
    input  logic       draw,
    input  logic [5:0] draw_x,
    input  logic [4:0] draw_y,
    input  logic [7:0] draw_byte,
    input  logic       clear,
    output logic       busy,
    output logic       done,
    output logic       collision
);

    // state   | meaning
    // IDLE    | waiting for draw or clear
    // READ_A  | read first byte {y,col}
    // WRITE_A | write first byte XOR (byte >> shift)
    // READ_B  | read second byte {y,col+1}
    // WRITE_B | write second byte XOR (byte << (8-shift))
    // CLEAR   | zero addresses 0..255, one per granted cycle
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ_A  = 3'd1,
        WRITE_A = 3'd2,
        READ_B  = 3'd3,
        WRITE_B = 3'd4,
        CLEAR   = 3'd5
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [7:0]  mem [0:255];
    logic [7:0]  ram_q;
    logic [7:0]  ram_addr;
    logic        ram_we;

    logic        disp_grant;
    logic        cpu_go;
    logic [7:0]  cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic        done_nxt;

    logic [4:0]  y_q;
    logic [2:0]  col_q;
    logic [2:0]  shift_q;
    logic [7:0]  byte_q;
    logic [2:0]  col_b;
    logic [15:0] mask_wide;
    logic [7:0]  mask_a;
    logic [7:0]  mask_b;
    logic [7:0]  cur_mask;

    logic [7:0]  hold_q;
    logic        rd_valid;
    logic [7:0]  old_byte;
    logic        coll_hit;
    logic [7:0]  clr_addr;
    logic        accept_draw;
    logic        accept_clear;

    // The display wins unless it is in its ack cycle, so the engine always
    // gets at least every other RAM cycle.
    assign disp_grant = scr_read && !scr_read_ack;
    assign cpu_go     = !disp_grant;

    assign accept_clear = (state == IDLE) && clear;
    assign accept_draw  = (state == IDLE) && !clear && draw;

    assign col_b     = col_q + 3'd1;
    assign mask_wide = {byte_q, 8'h00} >> shift_q;
    assign mask_a    = mask_wide[15:8];
    assign mask_b    = mask_wide[7:0];

    // RAM output is overwritten by any display read, so the engine keeps its
    // own copy for writes that get stalled.
    assign old_byte = rd_valid ? ram_q : hold_q;
    assign cur_mask = (state == WRITE_B) ? mask_b : mask_a;
    assign coll_hit = cpu_we && (state != CLEAR) && ((old_byte & cur_mask) != 8'h00);

    assign ram_addr = disp_grant ? scr_read_idx : cpu_addr;
    assign ram_we   = cpu_we;

    assign busy          = (state != IDLE);
    assign scr_read_byte = scr_read_ack ? ram_q : 8'h00;

    always_comb begin
        state_nxt = state;
        cpu_addr  = {y_q, col_q};
        cpu_wdata = 8'h00;
        cpu_we    = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (clear) begin
                    state_nxt = CLEAR;
                end else if (draw) begin
                    state_nxt = READ_A;
                end
            end
            READ_A: begin
                if (cpu_go) begin
                    state_nxt = WRITE_A;
                end
            end
            WRITE_A: begin
                cpu_wdata = old_byte ^ mask_a;
                cpu_we    = cpu_go;
                if (cpu_go) begin
                    if (shift_q == 3'd0) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = READ_B;
                    end
                end
            end
            READ_B: begin
                cpu_addr = {y_q, col_b};
                if (cpu_go) begin
                    state_nxt = WRITE_B;
                end
            end
            WRITE_B: begin
                cpu_addr  = {y_q, col_b};
                cpu_wdata = old_byte ^ mask_b;
                cpu_we    = cpu_go;
                if (cpu_go) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            CLEAR: begin
                cpu_addr = clr_addr;
                cpu_we   = cpu_go;
                if (cpu_go && (clr_addr == 8'hFF)) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Storage carries no reset so screen contents survive a reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= cpu_wdata;
        end
        ram_q <= mem[ram_addr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            done         <= 1'b0;
            collision    <= 1'b0;
            scr_read_ack <= 1'b0;
            rd_valid     <= 1'b0;
            hold_q       <= 8'h00;
            y_q          <= 5'd0;
            col_q        <= 3'd0;
            shift_q      <= 3'd0;
            byte_q       <= 8'h00;
            clr_addr     <= 8'h00;
        end else begin
            state        <= state_nxt;
            done         <= done_nxt;
            scr_read_ack <= disp_grant;
            rd_valid     <= ((state == READ_A) || (state == READ_B)) && cpu_go;
            if (rd_valid) begin
                hold_q <= ram_q;
            end
            if (accept_draw) begin
                y_q       <= draw_y;
                col_q     <= draw_x[5:3];
                shift_q   <= draw_x[2:0];
                byte_q    <= draw_byte;
                collision <= 1'b0;
            end else if (coll_hit) begin
                collision <= 1'b1;
            end
            if (accept_clear) begin
                clr_addr <= 8'h00;
            end else if ((state == CLEAR) && cpu_go) begin
                clr_addr <= clr_addr + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_screen_memory.sv
// Directed bench for screen_memory: clear, aligned/unaligned draws, collision,
// display-port contention and reset abort, against hand-computed values.
module tb_screen_memory;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scr_read = 1'b0;
    logic [7:0] scr_read_idx = 8'h00;
    logic [7:0] scr_read_byte;
    logic       scr_read_ack;
    logic       draw = 1'b0;
    logic [5:0] draw_x = 6'd0;
    logic [4:0] draw_y = 5'd0;
    logic [7:0] draw_byte = 8'h00;
    logic       clear = 1'b0;
    logic       busy;
    logic       done;
    logic       collision;

    int checks = 0;
    int errors = 0;

    screen_memory dut (
        .clk          (clk),
        .reset        (reset),
        .scr_read     (scr_read),
        .scr_read_idx (scr_read_idx),
        .scr_read_byte(scr_read_byte),
        .scr_read_ack (scr_read_ack),
        .draw         (draw),
        .draw_x       (draw_x),
        .draw_y       (draw_y),
        .draw_byte    (draw_byte),
        .clear        (clear),
        .busy         (busy),
        .done         (done),
        .collision    (collision)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // lat = cycle offset from the request cycle at which done is seen, -1 on timeout
    task automatic wait_done(input int start, output int lat);
        int n;
        n = start;
        while (done !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        lat = (done === 1'b1) ? n : -1;
    endtask

    task automatic disp_read(input logic [7:0] idx, output logic ack_seen, output logic [7:0] data);
        scr_read     = 1'b1;
        scr_read_idx = idx;
        tick();
        ack_seen = scr_read_ack;
        data     = scr_read_byte;
        scr_read = 1'b0;
        tick();
    endtask

    task automatic start_draw(input logic [5:0] x, input logic [4:0] y, input logic [7:0] b);
        draw      = 1'b1;
        draw_x    = x;
        draw_y    = y;
        draw_byte = b;
        tick();
        draw = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (collision !== 1'b0) begin errors++; $display("FAIL reset_collision: got %b expected 0", collision); end
        checks++; if (scr_read_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", scr_read_ack); end
        checks++; if (scr_read_byte !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h expected 00", scr_read_byte); end
        reset = 1'b0;
    endtask

    task automatic test_clear_reads();
        int lat;
        logic a;
        logic [7:0] d;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clear_busy: got %b expected 1", busy); end
        wait_done(1, lat);
        checks++; if (lat !== 257) begin errors++; $display("FAIL clear_latency: got %0d expected 257", lat); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_busy_at_done: got %b expected 0", busy); end
        disp_read(8'h00, a, d);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL read00_ack: got %b expected 1", a); end
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL read00_data: got %h expected 00", d); end
        disp_read(8'hFF, a, d);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL readFF_ack: got %b expected 1", a); end
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL readFF_data: got %h expected 00", d); end
    endtask

    task automatic test_draw_aligned();
        int lat;
        logic a;
        logic [7:0] d;
        start_draw(6'd0, 5'd0, 8'hF0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL aligned_busy: got %b expected 1", busy); end
        wait_done(1, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL aligned_latency: got %0d expected 3", lat); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL aligned_busy_at_done: got %b expected 0", busy); end
        checks++; if (collision !== 1'b0) begin errors++; $display("FAIL aligned_collision: got %b expected 0", collision); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL aligned_done_width: got %b expected 0", done); end
        disp_read(8'h00, a, d);
        checks++; if (d !== 8'hF0) begin errors++; $display("FAIL aligned_ram00: got %h expected F0", d); end
    endtask

    task automatic test_draw_collision();
        int lat;
        logic a;
        logic [7:0] d;
        start_draw(6'd0, 5'd0, 8'hF0);
        wait_done(1, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL coll_latency: got %0d expected 3", lat); end
        checks++; if (collision !== 1'b1) begin errors++; $display("FAIL coll_flag: got %b expected 1", collision); end
        disp_read(8'h00, a, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL coll_ram00: got %h expected 00", d); end
    endtask

    task automatic test_clear_wins();
        int lat;
        logic a;
        logic [7:0] d;
        clear = 1'b1;
        start_draw(6'd0, 5'd0, 8'hAA);
        clear = 1'b0;
        wait_done(1, lat);
        checks++; if (lat !== 257) begin errors++; $display("FAIL clearwins_latency: got %0d expected 257", lat); end
        checks++; if (collision !== 1'b1) begin errors++; $display("FAIL clearwins_collision: got %b expected 1", collision); end
        disp_read(8'h00, a, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL clearwins_ram00: got %h expected 00", d); end
    endtask

    task automatic test_draw_wrap();
        int lat;
        logic a;
        logic [7:0] d;
        // x=61: col 7, shift 5 -> 0xFF>>5=07 at 0xFF, 0xFF<<3=F8 wraps to 0xF8
        start_draw(6'd61, 5'd31, 8'hFF);
        wait_done(1, lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL wrap_latency: got %0d expected 5", lat); end
        checks++; if (collision !== 1'b0) begin errors++; $display("FAIL wrap_collision: got %b expected 0", collision); end
        disp_read(8'hFF, a, d);
        checks++; if (d !== 8'h07) begin errors++; $display("FAIL wrap_ramFF: got %h expected 07", d); end
        disp_read(8'hF8, a, d);
        checks++; if (d !== 8'hF8) begin errors++; $display("FAIL wrap_ramF8: got %h expected F8", d); end
    endtask

    task automatic test_busy_ignore();
        int lat;
        logic a;
        logic [7:0] d;
        start_draw(6'd0, 5'd1, 8'h3C);
        clear     = 1'b1;
        draw      = 1'b1;
        draw_x    = 6'd8;
        draw_y    = 5'd2;
        draw_byte = 8'h55;
        tick();
        clear = 1'b0;
        draw  = 1'b0;
        wait_done(2, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL ignore_latency: got %0d expected 3", lat); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_idle_after: got %b expected 0", busy); end
        disp_read(8'h08, a, d);
        checks++; if (d !== 8'h3C) begin errors++; $display("FAIL ignore_ram08: got %h expected 3C", d); end
        disp_read(8'h11, a, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL ignore_ram11: got %h expected 00", d); end
    endtask

    task automatic test_contention();
        int lat;
        int k;
        logic a;
        logic [7:0] d;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        wait_done(1, lat);
        checks++; if (lat !== 257) begin errors++; $display("FAIL cont_clear_latency: got %0d expected 257", lat); end
        // display grabs the port at N+2, N+4, N+6 while the engine needs it: 5 + 3
        scr_read     = 1'b1;
        scr_read_idx = 8'hF8;
        start_draw(6'd61, 5'd31, 8'hFF);
        k = 1;
        while (k < 20) begin
            checks++; if (scr_read_ack !== k[0]) begin errors++; $display("FAIL cont_ack_k%0d: got %b expected %b", k, scr_read_ack, k[0]); end
            if (scr_read_ack === 1'b1) begin
                checks++; if (scr_read_byte !== 8'h00) begin errors++; $display("FAIL cont_data_k%0d: got %h expected 00", k, scr_read_byte); end
            end
            if (done === 1'b1) break;
            tick();
            k++;
        end
        scr_read = 1'b0;
        checks++; if (k !== 8) begin errors++; $display("FAIL cont_latency: got %0d expected 8", k); end
        tick();
        checks++; if (collision !== 1'b0) begin errors++; $display("FAIL cont_collision: got %b expected 0", collision); end
        disp_read(8'hFF, a, d);
        checks++; if (d !== 8'h07) begin errors++; $display("FAIL cont_ramFF: got %h expected 07", d); end
        disp_read(8'hF8, a, d);
        checks++; if (d !== 8'hF8) begin errors++; $display("FAIL cont_ramF8: got %h expected F8", d); end
    endtask

    task automatic test_reset_mid_clear();
        int lat;
        logic a;
        logic [7:0] d;
        start_draw(6'd0, 5'd0, 8'hF0);
        wait_done(1, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL rmc_pre_latency: got %0d expected 3", lat); end
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmc_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rmc_done: got %b expected 0", done); end
        checks++; if (collision !== 1'b0) begin errors++; $display("FAIL rmc_collision: got %b expected 0", collision); end
        tick();
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rmc_no_done: got %b expected 0", done); end
        reset = 1'b0;
        // accepted on the first edge after release; RAM[0] was zeroed so 00^81
        start_draw(6'd0, 5'd0, 8'h81);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmc_accept: got %b expected 1", busy); end
        wait_done(1, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL rmc_latency: got %0d expected 3", lat); end
        checks++; if (collision !== 1'b0) begin errors++; $display("FAIL rmc_post_collision: got %b expected 0", collision); end
        disp_read(8'h00, a, d);
        checks++; if (d !== 8'h81) begin errors++; $display("FAIL rmc_ram00: got %h expected 81", d); end
        disp_read(8'hF8, a, d);
        checks++; if (d !== 8'hF8) begin errors++; $display("FAIL rmc_ramF8: got %h expected F8", d); end
        disp_read(8'hFF, a, d);
        checks++; if (d !== 8'h07) begin errors++; $display("FAIL rmc_ramFF: got %h expected 07", d); end
    endtask

    initial begin
        test_reset();
        test_clear_reads();
        test_draw_aligned();
        test_draw_collision();
        test_clear_wins();
        test_draw_wrap();
        test_busy_ignore();
        test_contention();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
